// File: rtl/egress_pop_arbiter.sv
// Drains destination FIFOs D0/D1 with round-robin pops and presents the words as one
// valid/ready stream through a 2-entry buffer. Define EGRESS_COUNT_EN for delivery counters.
module egress_pop_arbiter #(
    parameter int data_width = 6,
    parameter int cnt_width  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [data_width-1:0] data_out_D0,
    input  logic [data_width-1:0] data_out_D1,
    input  logic                  empty_fifo_D0,
    input  logic                  empty_fifo_D1,
    input  logic                  out_ready,
    output logic                  D0_pop,
    output logic                  D1_pop,
    output logic [data_width-1:0] data_out,
    output logic                  dest_out,
    output logic                  valid_out,
    output logic                  idle_out,
    output logic                  active_out,
    output logic [cnt_width-1:0]  cnt_D0,
    output logic [cnt_width-1:0]  cnt_D1
);

    typedef enum logic [1:0] {
        ST_RESET,
        ST_INIT,
        ST_IDLE,
        ST_ACTIVE
    } state_e;

    state_e                state_q, state_d;
    logic                  init_q;
    logic                  inflight_q, inflight_d;
    logic                  inflight_src_q, inflight_src_d;
    logic                  last_grant_q, last_grant_d;
    logic                  head_valid_q, head_valid_d;
    logic                  tail_valid_q, tail_valid_d;
    logic [data_width-1:0] head_data_q, head_data_d;
    logic [data_width-1:0] tail_data_q, tail_data_d;
    logic                  head_dest_q, head_dest_d;
    logic                  tail_dest_q, tail_dest_d;

    logic                  req0, req1;
    logic                  grant0, grant1;
    logic                  dequeue;
    logic [1:0]            pending;
    logic                  credit_ok;
    logic                  pop_en;
    logic                  pop_any;
    logic                  drained;
    logic [data_width-1:0] cap_data;

    assign req0    = !empty_fifo_D0;
    assign req1    = !empty_fifo_D1;
    assign dequeue = head_valid_q & out_ready;

    // Words owed downstream: the one in flight plus those already buffered.
    assign pending   = 2'(inflight_q) + 2'(head_valid_q) + 2'(tail_valid_q);
    assign credit_ok = (pending < 2'd2) || (dequeue && (pending == 2'd2));

    // Under contention the source that lost last time wins; last_grant = 1 favours D0.
    assign grant1 = req1 && (!req0 || !last_grant_q);
    assign grant0 = req0 && !grant1;

    // init_q delays the stop by one cycle so pops depend only on registered state.
    assign pop_en  = (state_q == ST_ACTIVE) && init_q && credit_ok;
    assign D0_pop  = pop_en && grant0;
    assign D1_pop  = pop_en && grant1;
    assign pop_any = D0_pop || D1_pop;

    assign drained = !inflight_q && !head_valid_q && !tail_valid_q && !pop_any;

    assign inflight_d     = pop_any;
    assign inflight_src_d = D1_pop;
    assign last_grant_d   = pop_any ? D1_pop : last_grant_q;
    assign cap_data       = inflight_src_q ? data_out_D1 : data_out_D0;

    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that leaves one unassigned infers a latch.
        head_valid_d = head_valid_q;
        head_data_d  = head_data_q;
        head_dest_d  = head_dest_q;
        tail_valid_d = tail_valid_q;
        tail_data_d  = tail_data_q;
        tail_dest_d  = tail_dest_q;

        if (dequeue) begin
            if (tail_valid_q) begin
                head_data_d  = tail_data_q;
                head_dest_d  = tail_dest_q;
                tail_valid_d = 1'b0;
            end else begin
                head_valid_d = 1'b0;
            end
        end

        // The FIFO read data arrives one cycle after the pop; it joins behind whatever remains.
        if (inflight_q) begin
            if (!head_valid_d) begin
                head_valid_d = 1'b1;
                head_data_d  = cap_data;
                head_dest_d  = inflight_src_q;
            end else begin
                tail_valid_d = 1'b1;
                tail_data_d  = cap_data;
                tail_dest_d  = inflight_src_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT:  if (init) state_d = ST_IDLE;
            ST_IDLE: begin
                if (!init) begin
                    if (drained) state_d = ST_INIT;
                end else if (req0 || req1) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (!init) begin
                    if (drained) state_d = ST_INIT;
                end else if (!req0 && !req1 && drained) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_RESET;
            init_q         <= 1'b0;
            inflight_q     <= 1'b0;
            inflight_src_q <= 1'b0;
            last_grant_q   <= 1'b1;
            head_valid_q   <= 1'b0;
            tail_valid_q   <= 1'b0;
            // NOTE: buffer storage is reset because head_data_q drives data_out, which must read 0 after reset.
            head_data_q    <= '0;
            head_dest_q    <= 1'b0;
            tail_data_q    <= '0;
            tail_dest_q    <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            state_q        <= state_d;
            init_q         <= init;
            inflight_q     <= inflight_d;
            inflight_src_q <= inflight_src_d;
            last_grant_q   <= last_grant_d;
            head_valid_q   <= head_valid_d;
            tail_valid_q   <= tail_valid_d;
            head_data_q    <= head_data_d;
            head_dest_q    <= head_dest_d;
            tail_data_q    <= tail_data_d;
            tail_dest_q    <= tail_dest_d;
        end
    end

    assign valid_out  = head_valid_q;
    assign data_out   = head_data_q;
    assign dest_out   = head_dest_q;
    assign idle_out   = (state_q == ST_IDLE);
    assign active_out = (state_q == ST_ACTIVE);

`ifdef EGRESS_COUNT_EN
    logic [cnt_width-1:0] cnt_d0_q, cnt_d0_d;
    logic [cnt_width-1:0] cnt_d1_q, cnt_d1_d;

    assign cnt_d0_d = (dequeue && !head_dest_q) ? cnt_d0_q + cnt_width'(1) : cnt_d0_q;
    assign cnt_d1_d = (dequeue &&  head_dest_q) ? cnt_d1_q + cnt_width'(1) : cnt_d1_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_d0_q <= '0;
            cnt_d1_q <= '0;
        end else begin
            cnt_d0_q <= cnt_d0_d;
            cnt_d1_q <= cnt_d1_d;
        end
    end

    assign cnt_D0 = cnt_d0_q;
    assign cnt_D1 = cnt_d1_q;
`else
    assign cnt_D0 = '0;
    assign cnt_D1 = '0;
`endif

endmodule

// File: tb/tb_egress_pop_arbiter.sv
// Self-checking bench for egress_pop_arbiter: FIFO models feed the DUT, and a queue-based
// reference predicts pops, the output stream, state flags and counters every cycle.
module tb_egress_pop_arbiter;

    localparam int DW = 6;
    localparam int CW = 8;
`ifdef EGRESS_COUNT_EN
    localparam int EXP_WRAP = 1;
`else
    localparam int EXP_WRAP = 0;
`endif

    localparam int M_RESET  = 0;
    localparam int M_INIT   = 1;
    localparam int M_IDLE   = 2;
    localparam int M_ACTIVE = 3;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          dest;
    } item_t;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
        logic          dest;
    } ev_t;

    logic          clk;
    logic          reset;
    logic          init;
    logic [DW-1:0] data_out_D0, data_out_D1;
    logic          empty_fifo_D0, empty_fifo_D1;
    logic          out_ready;
    logic          D0_pop, D1_pop;
    logic [DW-1:0] data_out;
    logic          dest_out, valid_out, idle_out, active_out;
    logic [CW-1:0] cnt_D0, cnt_D1;

    egress_pop_arbiter #(.data_width(DW), .cnt_width(CW)) dut (
        .clk(clk), .reset(reset), .init(init),
        .data_out_D0(data_out_D0), .data_out_D1(data_out_D1),
        .empty_fifo_D0(empty_fifo_D0), .empty_fifo_D1(empty_fifo_D1),
        .out_ready(out_ready),
        .D0_pop(D0_pop), .D1_pop(D1_pop),
        .data_out(data_out), .dest_out(dest_out), .valid_out(valid_out),
        .idle_out(idle_out), .active_out(active_out),
        .cnt_D0(cnt_D0), .cnt_D1(cnt_D1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    // Reference model state.
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    item_t         m_buf[$];
    item_t         m_fly;
    logic          m_inflight;
    logic          m_last;
    logic          m_init_prev;
    int            m_state;
    int            m_cnt0, m_cnt1;
    ev_t           pop_log[$];
    ev_t           hs_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        else n_pass++;
    endtask

    task automatic model_clear();
        q0.delete();
        q1.delete();
        m_buf.delete();
        m_inflight  = 1'b0;
        m_fly       = '0;
        m_last      = 1'b1;
        m_init_prev = 1'b0;
        m_state     = M_RESET;
        m_cnt0      = 0;
        m_cnt1      = 0;
        empty_fifo_D0 = 1'b1;
        empty_fifo_D1 = 1'b1;
        data_out_D0   = '0;
        data_out_D1   = '0;
    endtask

    task automatic push(input logic src, input logic [DW-1:0] w);
        if (src) q1.push_back(w);
        else     q0.push_back(w);
        empty_fifo_D0 = (q0.size() == 0);
        empty_fifo_D1 = (q1.size() == 0);
    endtask

    // One clock cycle: predict and compare at the falling edge, advance the model,
    // then let the FIFO models respond just after the rising edge.
    task automatic step();
        logic  exp_valid, deq, req0, req1, g, pop0, pop1, drained;
        int    pend;
        item_t it;
        @(negedge clk);
        cyc++;
        exp_valid = (m_buf.size() > 0);
        deq       = exp_valid && out_ready;
        req0      = (q0.size() > 0);
        req1      = (q1.size() > 0);
        pend      = int'(m_inflight) + m_buf.size() - int'(deq);
        g         = (req0 && req1) ? ~m_last : req1;
        pop0      = reset && (m_state == M_ACTIVE) && m_init_prev && (pend < 2) && (req0 || req1) && !g;
        pop1      = reset && (m_state == M_ACTIVE) && m_init_prev && (pend < 2) && (req0 || req1) && g;

        check("D0_pop", D0_pop, pop0);
        check("D1_pop", D1_pop, pop1);
        check("valid_out", valid_out, exp_valid);
        if (exp_valid) begin
            check("data_out", data_out, m_buf[0].data);
            check("dest_out", dest_out, m_buf[0].dest);
        end
        check("idle_out", idle_out, (m_state == M_IDLE));
        check("active_out", active_out, (m_state == M_ACTIVE));
        check("cnt_D0", cnt_D0, (EXP_WRAP != 0) ? (m_cnt0 % 256) : 0);
        check("cnt_D1", cnt_D1, (EXP_WRAP != 0) ? (m_cnt1 % 256) : 0);

        if (D0_pop) pop_log.push_back('{cyc, '0, 1'b0});
        if (D1_pop) pop_log.push_back('{cyc, '0, 1'b1});
        if (valid_out && out_ready) hs_log.push_back('{cyc, data_out, dest_out});

        if (reset) begin
            drained = !m_inflight && (m_buf.size() == 0) && !pop0 && !pop1;
            case (m_state)
                M_RESET: m_state = M_INIT;
                M_INIT:  if (init) m_state = M_IDLE;
                default: begin
                    if (!init) begin
                        if (drained) m_state = M_INIT;
                    end else if (m_state == M_IDLE && (req0 || req1)) begin
                        m_state = M_ACTIVE;
                    end else if (m_state == M_ACTIVE && !req0 && !req1 && drained) begin
                        m_state = M_IDLE;
                    end
                end
            endcase
            if (deq) begin
                it = m_buf.pop_front();
                if (it.dest) m_cnt1++;
                else         m_cnt0++;
            end
            if (m_inflight) m_buf.push_back(m_fly);
            m_inflight = pop0 || pop1;
            if (pop0) begin m_fly = '{q0.pop_front(), 1'b0}; m_last = 1'b0; end
            if (pop1) begin m_fly = '{q1.pop_front(), 1'b1}; m_last = 1'b1; end
            m_init_prev = init;
        end

        @(posedge clk);
        #1;
        if (pop0) data_out_D0 = m_fly.data;
        if (pop1) data_out_D1 = m_fly.data;
        empty_fifo_D0 = (q0.size() == 0);
        empty_fifo_D1 = (q1.size() == 0);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_logs();
        pop_log.delete();
        hs_log.delete();
    endtask

    initial begin
        logic [DW-1:0] exp_words[$];
        logic          exp_dests[$];
        int            low_left;

        reset     = 1'b0;
        init      = 1'b0;
        out_ready = 1'b1;
        model_clear();

        // Reset held for 4 cycles, then released with D0 loaded and init low.
        steps(4);
        check("rst valid_out", valid_out, 1'b0);
        check("rst data_out", data_out, '0);
        check("rst dest_out", dest_out, 1'b0);
        check("rst idle_out", idle_out, 1'b0);
        check("rst active_out", active_out, 1'b0);
        push(1'b0, 6'b110100);
        push(1'b0, 6'b110101);
        push(1'b0, 6'b110110);
        reset = 1'b1;
        steps(3);
        check("init low D0_pop", D0_pop, 1'b0);
        check("init low idle_out", idle_out, 1'b0);
        check("init low active_out", active_out, 1'b0);

        // Raise init: one IDLE cycle, then ACTIVE with a D0 pop.
        init = 1'b1;
        step();
        check("first idle_out", idle_out, 1'b1);
        check("first idle D0_pop", D0_pop, 1'b0);
        clear_logs();
        step();
        check("first active_out", active_out, 1'b1);
        check("first D0_pop", D0_pop, 1'b1);
        steps(10);
        check("burst pop count", pop_log.size(), 3);
        check("burst hs count", hs_log.size(), 3);
        exp_words = '{6'b110100, 6'b110101, 6'b110110};
        if (pop_log.size() == 3 && hs_log.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check("burst pop spacing", pop_log[i].cyc - pop_log[0].cyc, i);
                check("burst pop src", pop_log[i].dest, 1'b0);
                check("burst latency", hs_log[i].cyc - pop_log[i].cyc, 2);
                check("burst data", hs_log[i].data, exp_words[i]);
                check("burst dest", hs_log[i].dest, 1'b0);
            end
        end
        check("burst back to idle", idle_out, 1'b1);

        // D1 alone with downstream stalled: two pops fill the buffer, then hold.
        out_ready = 1'b0;
        clear_logs();
        for (int i = 0; i < 4; i++) push(1'b1, 6'h2a + DW'(i));
        steps(8);
        check("stall pop count", pop_log.size(), 2);
        check("stall valid_out", valid_out, 1'b1);
        check("stall data_out", data_out, 6'h2a);
        check("stall dest_out", dest_out, 1'b1);
        out_ready = 1'b1;
        steps(10);
        check("stall hs count", hs_log.size(), 4);
        if (hs_log.size() == 4)
            for (int i = 0; i < 4; i++) check("stall order", hs_log[i].data, 6'h2a + DW'(i));

        // Both sources loaded together: D0 wins first, then strict alternation.
        clear_logs();
        push(1'b0, 6'h05);
        push(1'b0, 6'h06);
        push(1'b1, 6'h39);
        push(1'b1, 6'h3a);
        steps(12);
        exp_words = '{6'h05, 6'h39, 6'h06, 6'h3a};
        exp_dests = '{1'b0, 1'b1, 1'b0, 1'b1};
        check("rr hs count", hs_log.size(), 4);
        if (hs_log.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("rr data", hs_log[i].data, exp_words[i]);
                check("rr dest", hs_log[i].dest, exp_dests[i]);
            end
        end

        // init drops in the cycle of the first pop: that word is delivered, nothing more is popped.
        clear_logs();
        push(1'b0, 6'h11);
        push(1'b0, 6'h12);
        push(1'b0, 6'h13);
        step();
        init = 1'b0;
        steps(8);
        check("drop pop count", pop_log.size(), 1);
        check("drop hs count", hs_log.size(), 1);
        if (hs_log.size() == 1) check("drop data", hs_log[0].data, 6'h11);
        check("drop idle_out", idle_out, 1'b0);
        check("drop active_out", active_out, 1'b0);
        init = 1'b1;
        steps(12);

        // Randomised traffic, backpressure and init toggling.
        low_left = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) < 4) push(1'b0, DW'($urandom));
            if ($urandom_range(0, 9) < 4) push(1'b1, DW'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            if (low_left > 0) low_left--;
            else if ($urandom_range(0, 99) < 3) low_left = $urandom_range(1, 6);
            init = (low_left == 0);
            step();
        end
        init      = 1'b1;
        out_ready = 1'b1;
        steps(60);

        // Reset asserted mid-burst clears everything immediately.
        for (int i = 0; i < 4; i++) begin
            push(1'b0, DW'($urandom));
            push(1'b1, DW'($urandom));
        end
        steps(4);
        #2;
        reset = 1'b0;
        #1;
        check("async rst D0_pop", D0_pop, 1'b0);
        check("async rst D1_pop", D1_pop, 1'b0);
        check("async rst valid_out", valid_out, 1'b0);
        check("async rst data_out", data_out, '0);
        check("async rst dest_out", dest_out, 1'b0);
        check("async rst active_out", active_out, 1'b0);
        check("async rst cnt_D0", cnt_D0, '0);
        check("async rst cnt_D1", cnt_D1, '0);
        model_clear();
        steps(2);
        reset = 1'b1;
        steps(4);

        // 257 D0 words: the D0 counter wraps to 1 when counting is built in.
        clear_logs();
        for (int i = 0; i < 257; i++) push(1'b0, DW'(i));
        steps(280);
        check("wrap hs count", hs_log.size(), 257);
        check("wrap cnt_D0", cnt_D0, EXP_WRAP);
        check("wrap cnt_D1", cnt_D1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
